// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-word load/store responder with programmable wait states
// Optional memory-mapped I/O port at 0xFFFF_FF00/04 enabled by DMEM_MMIO_EN.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [31:0] io_in,
    output logic [31:0] io_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        err_q;

    logic          accept;
    logic          resp_active;
    logic          misaligned;
    logic          in_range;
    logic          mmio_out_sel;
    logic          mmio_in_sel;
    logic          fault;
    logic          commit;
    logic [AW-1:0] word_idx;
    logic [31:0]   live_rdata;

    // Ready and response are gated by reset so nothing is accepted or
    // reported in a cycle that reset is about to discard.
    assign req_ready   = (state == IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign resp_active = (state == RESP) && !reset;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    wait_cnt_next = WAIT_LOAD;
                    state_next    = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign misaligned = (lat_addr[1:0] != 2'b00);
    assign in_range   = (lat_addr[31:AW+2] == '0);
    assign word_idx   = lat_addr[AW+1:2];

`ifdef DMEM_MMIO_EN
    logic [31:0] io_out_q;

    assign mmio_out_sel = (lat_addr == 32'hFFFF_FF00);
    assign mmio_in_sel  = (lat_addr == 32'hFFFF_FF04);
    assign io_out       = io_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            io_out_q <= 32'd0;
        end else if (resp_active && lat_we && mmio_out_sel) begin
            io_out_q <= lat_wdata;
        end
    end
`else
    logic unused_io;

    assign mmio_out_sel = 1'b0;
    assign mmio_in_sel  = 1'b0;
    assign io_out       = 32'd0;
    assign unused_io    = ^io_in;
`endif

    assign fault  = misaligned || (!in_range && !mmio_out_sel && !mmio_in_sel);
    assign commit = resp_active && lat_we && !fault && in_range;

    always_comb begin
        live_rdata = 32'd0;
        if (!fault) begin
            if (mmio_out_sel) begin
                live_rdata = io_out;
            end else if (mmio_in_sel) begin
                live_rdata = io_in;
            end else begin
                live_rdata = mem[word_idx];
            end
        end
    end

    // Response fields are live during RESP and hold their last value after.
    assign resp_valid = resp_active;
    assign resp_rdata = resp_active ? live_rdata : rdata_q;
    assign resp_err   = resp_active ? fault : err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (resp_active) begin
                rdata_q <= live_rdata;
                err_q   <= fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[word_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench, instance 0 LATENCY=2, instance 1 LATENCY=0
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata [2];
    logic [1:0]  resp_err;
    logic [31:0] io_in;
    logic [31:0] io_out     [2];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .io_in(io_in), .io_out(io_out[0])
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .io_in(io_in), .io_out(io_out[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request on instance i; called at a negedge, returns at the
    // negedge where the instance is back in IDLE.
    task automatic xact(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int busy, output int nresp, output int acc);
        int guard;
        guard = 0;
        rdata = 32'd0;
        err   = 1'b0;
        lat   = 0;
        busy  = 0;
        nresp = 0;
        while (!req_ready[i] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 32'(guard < 50), 32'd1);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        acc = cyc;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!hold) begin
                req_valid[i] = 1'b0;
            end else begin
                req_we[i]    = 1'b1;
                req_addr[i]  = addr ^ 32'h4;
                req_wdata[i] = ~wdata;
            end
            if (resp_valid[i]) begin
                nresp++;
                lat   = k;
                rdata = resp_rdata[i];
                err   = resp_err[i];
            end
            if (req_ready[i]) break;
            busy++;
        end
        req_valid[i] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, busy, nresp, acc_a, acc_b, seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
        end
        io_in = 32'd0;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        check("valid_in_reset", 32'(resp_valid), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd3);
        check("resp_valid_reset", 32'(resp_valid), 32'd0);
        check("rdata_reset", resp_rdata[0], 32'd0);
        check("err_reset", 32'(resp_err), 32'd0);
        check("io_out_reset", io_out[0], 32'd0);

        // LATENCY=2 store and load
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("l2_store_lat", 32'(lat), 32'd3);
        check("l2_store_busy", 32'(busy), 32'd3);
        check("l2_store_nresp", 32'(nresp), 32'd1);
        check("l2_store_err", 32'(er), 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("l2_load_data", rd, 32'hDEADBEEF);
        check("l2_load_err", 32'(er), 32'd0);
        repeat (3) @(negedge clk);
        check("rdata_held", resp_rdata[0], 32'hDEADBEEF);

        // LATENCY=0 back-to-back
        xact(1, 1'b1, 32'h3C, 32'h1234, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("l0_store_lat", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h3C, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_b);
        check("l0_load_lat", 32'(lat), 32'd1);
        check("l0_load_data", rd, 32'h00001234);
        check("l0_accept_spacing", 32'(acc_b - acc_a), 32'd2);

        // Faults and range boundary
        xact(1, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, rd, er, lat, busy, nresp, acc_a);
        xact(1, 1'b1, 32'h102, 32'h99, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("misaligned_store_err", 32'(er), 32'd1);
        xact(1, 1'b1, 32'h100, 32'h55, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("oor_store_err", 32'(er), 32'd1);
        xact(1, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("ram_unchanged", rd, 32'hCAFEF00D);
        xact(1, 1'b0, 32'h100, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("oor_load_err", 32'(er), 32'd1);
        check("oor_load_data", rd, 32'd0);
        xact(1, 1'b1, 32'hFC, 32'h0BADC0DE, 1'b0, rd, er, lat, busy, nresp, acc_a);
        xact(1, 1'b0, 32'hFC, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("top_word_err", 32'(er), 32'd0);
        check("top_word_data", rd, 32'h0BADC0DE);

        // Reset in WAIT aborts the pending store
        xact(0, 1'b1, 32'h20, 32'h11111111, 1'b0, rd, er, lat, busy, nresp, acc_a);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hAAAA5555;
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        check("ready_low_reset_wait", 32'(req_ready[0]), 32'd0);
        seen = 32'(resp_valid[0]);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            seen += 32'(resp_valid[0]);
            @(negedge clk);
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_ready", 32'(req_ready[0]), 32'd1);
        xact(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("abort_no_commit", rd, 32'h11111111);

        // Request held valid through WAIT/RESP
        xact(0, 1'b1, 32'h34, 32'h12121212, 1'b0, rd, er, lat, busy, nresp, acc_a);
        xact(0, 1'b1, 32'h30, 32'h600DF00D, 1'b1, rd, er, lat, busy, nresp, acc_a);
        check("hold_nresp", 32'(nresp), 32'd1);
        check("hold_busy", 32'(busy), 32'd3);
        xact(0, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("hold_latched_data", rd, 32'h600DF00D);
        xact(0, 1'b0, 32'h34, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("hold_neighbor_intact", rd, 32'h12121212);

        // MMIO addresses
        io_in = 32'h5A5A5A5A;
`ifdef DMEM_MMIO_EN
        xact(0, 1'b1, 32'hFFFF_FF00, 32'h000000A5, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("mmio_store_err", 32'(er), 32'd0);
        check("mmio_io_out", io_out[0], 32'h000000A5);
        xact(0, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("mmio_io_in_data", rd, 32'h5A5A5A5A);
        check("mmio_io_in_err", 32'(er), 32'd0);
        xact(0, 1'b1, 32'hFFFF_FF04, 32'h1, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("mmio_in_store_err", 32'(er), 32'd0);
        xact(0, 1'b0, 32'hFFFF_FF00, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("mmio_io_out_read", rd, 32'h000000A5);
`else
        xact(0, 1'b1, 32'hFFFF_FF00, 32'h000000A5, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("nommio_store_err", 32'(er), 32'd1);
        check("nommio_io_out", io_out[0], 32'd0);
        xact(0, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b0, rd, er, lat, busy, nresp, acc_a);
        check("nommio_load_err", 32'(er), 32'd1);
        check("nommio_load_data", rd, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
